// File: rtl/wbuart_lite_if.sv
// Wishbone-classic bus bundle for wbuart_lite.
interface wbuart_lite_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wbuart_lite.sv
// wbuart_lite: Wishbone-classic UART with TX FIFO, single-entry RX holding
// register, programmable baud divider and level interrupt.
// Optional macro WBUART_LOOPBACK_EN implements CTRL[18] internal loopback.
module wbuart_lite #(
    parameter logic [15:0] CLKDIV_RESET  = 16'd347,
    parameter int unsigned TX_FIFO_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    wbuart_lite_if.slave wbs,
    input  logic         uart_rx_i,
    output logic         uart_tx_o,
    output logic         irq_o
);

    localparam int unsigned AW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    // Bus / register state
    logic        ack_q;
    logic [31:0] dat_q;
    logic [15:0] clkdiv_q;
    logic        rx_irq_en_q, txe_irq_en_q;
    logic        rx_valid_q;
    logic [7:0]  rx_data_q;
    logic        rx_overrun_q, frame_err_q, tx_ovf_q;
    logic        irq_q;
`ifdef WBUART_LOOPBACK_EN
    logic        loopback_q;
    logic        tx_ser_q;
`endif

    // FIFO state
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // TX state
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_ser_d;
    logic        uart_tx_q;
    logic        tx_pop_c;

    // RX state
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_load_c, rx_ferr_c, rx_ovr_c;
    logic        rx_src_c;

    // Combinational helpers
    logic        req_c, wr_c, rd_c;
    logic [1:0]  reg_c;
    logic        push_req_c, push_c, ovf_set_c;
    logic        fifo_full_c, fifo_empty_c, tx_empty_c;
    logic        ctrl_wr_c, rx_rd_clr_c;
    logic [2:0]  w1c_c;
    logic        loopback_c;
    logic [31:0] rdata_c;
    logic [15:0] period_c, reload_c, half_c;
    logic        unused_c;

    // Bus decode; a request is only taken while no ack is outstanding
    assign req_c       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign wr_c        = req_c & wbs.wbs_we_i;
    assign rd_c        = req_c & ~wbs.wbs_we_i;
    assign reg_c       = wbs.wbs_adr_i[3:2];
    assign push_req_c  = wr_c & (reg_c == 2'd0) & wbs.wbs_sel_i[0];
    assign ctrl_wr_c   = wr_c & (reg_c == 2'd3);
    assign rx_rd_clr_c = rd_c & (reg_c == 2'd1) & rx_valid_q;
    assign w1c_c       = (wr_c && reg_c == 2'd2 && wbs.wbs_sel_i[0]) ? wbs.wbs_dat_i[5:3] : 3'b000;
    assign unused_c    = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:18], wbs.wbs_sel_i[3]};

    assign fifo_full_c  = (count_q == CW'(TX_FIFO_DEPTH));
    assign fifo_empty_c = (count_q == '0);
    assign push_c       = push_req_c & (~fifo_full_c | tx_pop_c);
    assign ovf_set_c    = push_req_c & fifo_full_c & ~tx_pop_c;
    assign tx_empty_c   = fifo_empty_c & (tx_state_q == ST_IDLE);

    assign period_c = (clkdiv_q == 16'd0) ? 16'd1 : clkdiv_q;
    assign reload_c = period_c - 16'd1;
    assign half_c   = period_c >> 1;

`ifdef WBUART_LOOPBACK_EN
    assign loopback_c = loopback_q;
    assign rx_src_c   = loopback_q ? tx_ser_q : uart_rx_i;
`else
    assign loopback_c = 1'b0;
    assign rx_src_c   = uart_rx_i;
`endif

    // Register read mux, sampled in the request cycle
    always_comb begin
        rdata_c = 32'd0;
        case (reg_c)
            2'd1: rdata_c = {23'd0, rx_valid_q, rx_data_q};
            2'd2: rdata_c = {26'd0, tx_ovf_q, frame_err_q, rx_overrun_q,
                             rx_valid_q, fifo_full_c, tx_empty_c};
            2'd3: rdata_c = {13'd0, loopback_c, txe_irq_en_q, rx_irq_en_q, clkdiv_q};
            default: rdata_c = 32'd0;
        endcase
    end

    // Bus response, control, status and interrupt registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ack_q        <= 1'b0;
            dat_q        <= 32'd0;
            clkdiv_q     <= CLKDIV_RESET;
            rx_irq_en_q  <= 1'b0;
            txe_irq_en_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_ovf_q     <= 1'b0;
            irq_q        <= 1'b0;
`ifdef WBUART_LOOPBACK_EN
            loopback_q   <= 1'b0;
`endif
        end else begin
            ack_q <= req_c;
            dat_q <= rd_c ? rdata_c : 32'd0;
            if (ctrl_wr_c) begin
                if (wbs.wbs_sel_i[0]) clkdiv_q[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) clkdiv_q[15:8] <= wbs.wbs_dat_i[15:8];
                if (wbs.wbs_sel_i[2]) begin
                    rx_irq_en_q  <= wbs.wbs_dat_i[16];
                    txe_irq_en_q <= wbs.wbs_dat_i[17];
`ifdef WBUART_LOOPBACK_EN
                    loopback_q   <= wbs.wbs_dat_i[18];
`endif
                end
            end
            // A load in the same cycle as a clearing read wins
            if (rx_load_c) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift_q;
            end else if (rx_rd_clr_c) begin
                rx_valid_q <= 1'b0;
            end
            rx_overrun_q <= (rx_overrun_q & ~w1c_c[0]) | rx_ovr_c;
            frame_err_q  <= (frame_err_q  & ~w1c_c[1]) | rx_ferr_c;
            tx_ovf_q     <= (tx_ovf_q     & ~w1c_c[2]) | ovf_set_c;
            irq_q        <= (rx_irq_en_q & rx_valid_q) | (txe_irq_en_q & tx_empty_c);
        end
    end

    // TX FIFO storage (no reset needed on payload)
    always_ff @(posedge clk_i) begin
        if (push_c) fifo_mem[wr_ptr_q] <= wbs.wbs_dat_i[7:0];
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (tx_pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_c, tx_pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // TX FSM next state and serializer bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop_c   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    tx_pop_c   = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                    tx_cnt_d   = reload_c;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = reload_c;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = reload_c;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == 16'd0) tx_state_d = ST_IDLE;
                else                   tx_cnt_d   = tx_cnt_q - 16'd1;
            end
            default: tx_state_d = ST_IDLE;
        endcase
        tx_ser_d = 1'b1;
        if (tx_state_d == ST_START)     tx_ser_d = 1'b0;
        else if (tx_state_d == ST_DATA) tx_ser_d = tx_shift_d[0];
    end

    // TX FSM state register and registered line output
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            uart_tx_q  <= 1'b1;
`ifdef WBUART_LOOPBACK_EN
            tx_ser_q   <= 1'b1;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
`ifdef WBUART_LOOPBACK_EN
            tx_ser_q   <= tx_ser_d;
            uart_tx_q  <= loopback_q ? 1'b1 : tx_ser_d;
`else
            uart_tx_q  <= tx_ser_d;
`endif
        end
    end

    // RX FSM next state and frame outcome
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load_c  = 1'b0;
        rx_ferr_c  = 1'b0;
        rx_ovr_c   = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    rx_cnt_d   = half_c;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        rx_cnt_d   = reload_c;
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                    end else begin
                        rx_state_d = ST_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d   = reload_c;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = ST_IDLE;
                    if (!rx_s2_q)                         rx_ferr_c = 1'b1;
                    else if (rx_valid_q && !rx_rd_clr_c)  rx_ovr_c  = 1'b1;
                    else                                  rx_load_c = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX synchronizer and FSM state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_s1_q    <= rx_src_c;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign uart_tx_o     = uart_tx_q;
    assign irq_o         = irq_q;

endmodule

// File: doc/wbuart_lite.md
Name: wbuart_lite

Overview:
Wishbone-classic slave UART peripheral attached to the data-side Wishbone master port of the data RAM mux. The CPU reaches it through the data bus; it replaces the external UART wrapper.
Contents:
- Byte-wide TX FIFO feeding an 8N1 serializer.
- Single-entry RX holding register fed by an 8N1 deserializer.
- Programmable baud divider.
- Status/control registers and a level interrupt.

Parameters:
CLKDIV_RESET, 16'd347, reset value of bit period in clk_i cycles (40 MHz / 115200)
TX_FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2

Ports:
clk_i  input  1  system clock
rstn_i  input  1  reset; synchronous to clk_i, active-low
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  write enable
wbs_adr_i  input  32  byte address; only [3:2] decoded
wbs_dat_i  input  32  write data
wbs_sel_i  input  4  byte selects
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data, valid with ack
uart_rx_i  input  1  serial input, asynchronous
uart_tx_o  output  1  serial output, idle high
irq_o  output  1  level interrupt

Behaviour:
Reset:
- wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, irq_o=0.
- FIFO empty, both FSMs in IDLE, all status/ctrl bits 0, clkdiv=CLKDIV_RESET.
- RX synchronizer flops reset to 1.
- Reset mid-frame aborts immediately; uart_tx_o is 1 the cycle after rstn_i sampled low.

Bus:
- Request when cyc&stb&!ack. ack_o is registered: high exactly one cycle later, then low. Max one access per 2 cycles.
- Side effects (push/pop/clear) occur in the request cycle.

Register map (adr[3:2]):
- 0x0 TXDATA, W: if sel[0], push dat_i[7:0]. If FIFO full and no pop in the same cycle, the write is dropped and tx_ovf is set. Reads return 0.
- 0x4 RXDATA, R: returns {23'b0, rx_valid, rx_data}. A read with rx_valid=1 clears rx_valid. Writes are ignored.
- 0x8 STATUS, R:
  - bit0 tx_empty (FIFO empty and TX FSM IDLE)
  - bit1 tx_full
  - bit2 rx_valid
  - bit3 rx_overrun (sticky)
  - bit4 frame_err (sticky)
  - bit5 tx_ovf (sticky)
  - Write-1-to-clear on bits 3..5 (needs sel[0]); other bits read-only.
- 0xC CTRL, R/W, per-byte sel honoured:
  - [15:0] clkdiv
  - [16] irq_rx_en
  - [17] irq_txempty_en
  - [18] loopback (see Optional Feature)
  - Other bits read 0.

Baud:
- Bit period P = max(clkdiv,1) cycles.
- A clkdiv write mid-frame takes effect at the next bit-counter reload.

TX FSM (IDLE, START, DATA, STOP):
- IDLE with FIFO non-empty: pop the head into the shift register and go to START.
- START drives 0 for P cycles.
- DATA drives 8 bits LSB first, P cycles each.
- STOP drives 1 for P cycles, then goes to IDLE. IDLE lasts exactly one cycle if the FIFO is non-empty.
- Frame-to-frame spacing is 10P+1 cycles.

RX FSM (IDLE, START, DATA, STOP):
- Input is a 2-flop synchronizer.
- IDLE: a sampled falling edge enters START.
- START: at P>>1 cycles, if the line is still 0 go to DATA, else return to IDLE (glitch reject).
- DATA: sample every P cycles, LSB first, 8 bits.
- STOP: sample the stop bit P cycles after the last data bit.
  - Stop=0: set frame_err, discard byte.
  - Stop=1 and rx_valid=1: set rx_overrun, keep old data.
  - Otherwise load rx_data and set rx_valid.
- A RXDATA read in the same cycle as a load: the load wins, rx_valid stays 1, no overrun.

FIFO:
- Circular, pointer wrap at TX_FIFO_DEPTH.
- Simultaneous push and pop while full: both occur, count unchanged.

Interrupt:
- irq_o registered = (irq_rx_en & rx_valid) | (irq_txempty_en & tx_empty).

Optional Feature:
WBUART_LOOPBACK_EN defined:
- CTRL[18] is implemented.
- When 1, the RX synchronizer input is the internal TX serializer output and uart_tx_o is forced to 1.
Not defined:
- CTRL[18] reads 0 and writes are ignored.
- RX always uses uart_rx_i.
- No loopback mux is synthesized.

Test Plan:
1. Reset, read STATUS and CTRL -> STATUS=0x00000001, CTRL=0x0000015B, uart_tx_o=1, irq_o=0.
2. CTRL=0x4, write TXDATA=0xA5 -> uart_tx_o gives start 0, then 1,0,1,0,0,1,0,1, then stop 1, each 4 cycles (40 cycles); then STATUS bit0=1.
3. CTRL=100, write TXDATA ten times back-to-back -> 10th write dropped, STATUS=0x22 after the 10th write; exactly 9 frames transmitted in order.
4. CTRL=8, drive RX frame 0x3C -> STATUS bit2=1, RXDATA=0x13C, then bit2=0. Two frames 0x11 and 0x22 without a read -> rx_overrun=1, RXDATA=0x111.
5. RX frame with stop bit 0 -> frame_err=1, rx_valid=0. Write STATUS=0x10 -> bit4=0. A 1-cycle low glitch on rx at P=8 -> no status change.
6. With WBUART_LOOPBACK_EN: CTRL=0x50008 (irq_rx_en, loopback, P=8), write 0x5A -> uart_tx_o constant 1, RXDATA=0x15A, irq_o=1 until the RXDATA read.
